// File: rtl/snake_pkg.sv
// Shared encodings for the snake turn-request path: headings and button indices.
package snake_pkg;

    // Heading encoding. Opposite headings differ only in bit 1.
    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_e;

    // Bit positions within the raw button bus.
    localparam int BTN_RST   = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_DOWN  = 4;
    localparam int NUM_BTN   = 5;

    // Reverse heading: right<->left, down<->up.
    function automatic logic [1:0] dir_opposite(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchronizer, stability counter, and a
// one-cycle pulse on each accepted 0->1 change of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    logic w_differ;
    logic w_expire;

    // The counter tracks how long the synchronized input has disagreed with
    // the accepted level; the last disagreeing sample commits the change.
    assign w_differ = (r_sync1 != r_level);
    assign w_expire = w_differ && (r_cnt == CNT_LAST);

    // Synchronize, count consecutive disagreeing samples, commit and flag rises.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= i_btn;
            r_sync1 <= r_sync0;
            r_press <= 1'b0;
            if (w_expire) begin
                r_level <= r_sync1;
                r_press <= r_sync1;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt   <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/turn_queue.sv
// Debounced direction buttons feeding a small FIFO of turn requests; each
// game tick pops one request into the snake heading. Restart flushes all.
module turn_queue
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DEPTH           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn,
    input  logic       game_tick,
    output logic [1:0] dir,
    output logic       dir_changed,
    output logic       restart,
    output logic [3:0] q_count,
    output logic       drop
);

    localparam int         PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] FULL  = 4'(DEPTH);

    logic [NUM_BTN-1:0] w_press;

    logic [1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [3:0]       r_count;
    logic [1:0]       r_dir;
    logic             r_dir_changed;
    logic             r_restart;
    logic             r_drop;

    logic             w_restart;
    logic             w_dir_vld;
    logic [1:0]       w_dir_req;
    logic [PTR_W-1:0] w_last_ptr;
    logic [1:0]       w_ref;
    logic             w_reject;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn_debounce (
                .i_clk  (clk),
                .i_rst  (rst),
                .i_btn  (btn[g]),
                .o_press(w_press[g])
            );
        end
    endgenerate

    assign w_restart = w_press[BTN_RST];

    // Pick a single direction press per cycle: up > down > left > right.
    always_comb begin
        w_dir_vld = 1'b0;
        w_dir_req = DIR_RIGHT;
        if (w_press[BTN_UP]) begin
            w_dir_vld = 1'b1;
            w_dir_req = DIR_UP;
        end else if (w_press[BTN_DOWN]) begin
            w_dir_vld = 1'b1;
            w_dir_req = DIR_DOWN;
        end else if (w_press[BTN_LEFT]) begin
            w_dir_vld = 1'b1;
            w_dir_req = DIR_LEFT;
        end else if (w_press[BTN_RIGHT]) begin
            w_dir_vld = 1'b1;
            w_dir_req = DIR_RIGHT;
        end
    end

    // A new request is judged against the heading the snake will have once
    // everything already queued has been applied.
    assign w_last_ptr = r_tail - PTR_W'(1);
    assign w_ref      = (r_count != 4'd0) ? r_mem[w_last_ptr] : r_dir;
    assign w_reject   = (w_dir_req == w_ref) || (w_dir_req == dir_opposite(w_ref));
    assign w_full     = (r_count == FULL);

    // Restart wins over every same-cycle press and tick.
    assign w_push = !w_restart && w_dir_vld && !w_reject && !w_full;
    assign w_drop = !w_restart && w_dir_vld && (w_reject || w_full);
    assign w_pop  = !w_restart && game_tick && (r_count != 4'd0);

    // Queue storage holds data only; validity is carried by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= w_dir_req;
        end
    end

    // Pointers, occupancy, heading and the registered event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= 4'd0;
            r_dir         <= DIR_RIGHT;
            r_dir_changed <= 1'b0;
            r_restart     <= 1'b0;
            r_drop        <= 1'b0;
        end else if (w_restart) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= 4'd0;
            r_dir         <= DIR_RIGHT;
            r_dir_changed <= 1'b0;
            r_restart     <= 1'b1;
            r_drop        <= 1'b0;
        end else begin
            r_restart     <= 1'b0;
            r_drop        <= w_drop;
            r_dir_changed <= w_pop;
            if (w_pop) begin
                r_dir  <= r_mem[r_head];
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dir         = r_dir;
    assign dir_changed = r_dir_changed;
    assign restart     = r_restart;
    assign q_count     = r_count;
    assign drop        = r_drop;

endmodule

// File: tb/tb_turn_queue.sv
// Directed bench for turn_queue with a short debounce window and a 4-deep queue.
module tb_turn_queue;

    logic       clk;
    logic       rst;
    logic [4:0] btn;
    logic       game_tick;
    logic [1:0] dir;
    logic       dir_changed;
    logic       restart;
    logic [3:0] q_count;
    logic       drop;

    int checks = 0;
    int errors = 0;
    int n_drop = 0;
    int n_chg  = 0;
    int n_rst  = 0;

    turn_queue #(
        .DEBOUNCE_CYCLES(4),
        .DEPTH          (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .game_tick  (game_tick),
        .dir        (dir),
        .dir_changed(dir_changed),
        .restart    (restart),
        .q_count    (q_count),
        .drop       (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled on the inactive edge.
    always @(negedge clk) begin
        if (drop)        n_drop++;
        if (dir_changed) n_chg++;
        if (restart)     n_rst++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Hold buttons long enough for one accepted press, then release fully.
    task automatic press(input logic [4:0] b);
        btn = b;
        repeat (8) @(negedge clk);
        btn = 5'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic tick();
        game_tick = 1'b1;
        @(negedge clk);
        game_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = 5'b0; game_tick = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dir !== 2'd0) begin errors++; $display("FAIL reset_dir got %0d exp 0", dir); end
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL reset_q got %0d exp 0", q_count); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %0b exp 0", drop); end
        checks++; if (restart !== 1'b0) begin errors++; $display("FAIL reset_restart got %0b exp 0", restart); end
        checks++; if (dir_changed !== 1'b0) begin errors++; $display("FAIL reset_chg got %0b exp 0", dir_changed); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bounce();
        int d0, c0;
        d0 = n_drop; c0 = n_chg;
        btn = 5'b10000;
        repeat (3) @(negedge clk);
        btn = 5'b0;
        repeat (6) @(negedge clk);
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL bounce_short got %0d exp 0", q_count); end
        btn = 5'b10000;
        repeat (10) @(negedge clk);
        btn = 5'b0;
        repeat (8) @(negedge clk);
        checks++; if (q_count !== 4'd1) begin errors++; $display("FAIL bounce_q got %0d exp 1", q_count); end
        tick();
        checks++; if (dir !== 2'd1) begin errors++; $display("FAIL bounce_dir got %0d exp 1", dir); end
        checks++; if (dir_changed !== 1'b1) begin errors++; $display("FAIL bounce_chg_pulse got %0b exp 1", dir_changed); end
        repeat (3) @(negedge clk);
        checks++; if (n_chg - c0 !== 1) begin errors++; $display("FAIL bounce_chg_count got %0d exp 1", n_chg - c0); end
        checks++; if (n_drop - d0 !== 0) begin errors++; $display("FAIL bounce_drop got %0d exp 0", n_drop - d0); end
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL bounce_q_after got %0d exp 0", q_count); end
    endtask

    task automatic test_restart_empty();
        int r0;
        r0 = n_rst;
        press(5'b00001);
        checks++; if (n_rst - r0 !== 1) begin errors++; $display("FAIL rst_empty_pulse got %0d exp 1", n_rst - r0); end
        checks++; if (dir !== 2'd0) begin errors++; $display("FAIL rst_empty_dir got %0d exp 0", dir); end
    endtask

    task automatic test_filter();
        int d0;
        d0 = n_drop;
        press(5'b00100);
        checks++; if (n_drop - d0 !== 1) begin errors++; $display("FAIL filter_left_drop got %0d exp 1", n_drop - d0); end
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL filter_left_q got %0d exp 0", q_count); end
        press(5'b01000);
        checks++; if (n_drop - d0 !== 2) begin errors++; $display("FAIL filter_right_drop got %0d exp 2", n_drop - d0); end
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL filter_right_q got %0d exp 0", q_count); end
        press(5'b00010);
        checks++; if (q_count !== 4'd1) begin errors++; $display("FAIL filter_up_q got %0d exp 1", q_count); end
        checks++; if (n_drop - d0 !== 2) begin errors++; $display("FAIL filter_up_drop got %0d exp 2", n_drop - d0); end
    endtask

    task automatic test_overflow();
        int d0;
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'd3; exp_seq[1] = 2'd2; exp_seq[2] = 2'd1; exp_seq[3] = 2'd0;
        press(5'b00100);
        press(5'b10000);
        press(5'b01000);
        checks++; if (q_count !== 4'd4) begin errors++; $display("FAIL ovf_full got %0d exp 4", q_count); end
        d0 = n_drop;
        press(5'b00010);
        checks++; if (n_drop - d0 !== 1) begin errors++; $display("FAIL ovf_drop got %0d exp 1", n_drop - d0); end
        checks++; if (q_count !== 4'd4) begin errors++; $display("FAIL ovf_q got %0d exp 4", q_count); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (dir !== exp_seq[i]) begin errors++; $display("FAIL ovf_pop%0d got %0d exp %0d", i, dir, exp_seq[i]); end
            @(negedge clk);
        end
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL ovf_empty got %0d exp 0", q_count); end
        tick();
        checks++; if (dir_changed !== 1'b0 || dir !== 2'd0) begin errors++; $display("FAIL empty_tick got chg=%0b dir=%0d exp chg=0 dir=0", dir_changed, dir); end
    endtask

    task automatic test_priority();
        int d0;
        d0 = n_drop;
        press(5'b11110);
        checks++; if (q_count !== 4'd1) begin errors++; $display("FAIL prio_q got %0d exp 1", q_count); end
        checks++; if (n_drop - d0 !== 0) begin errors++; $display("FAIL prio_drop got %0d exp 0", n_drop - d0); end
        tick();
        checks++; if (dir !== 2'd3) begin errors++; $display("FAIL prio_dir got %0d exp 3", dir); end
    endtask

    task automatic test_back_to_back();
        press(5'b00001);
        btn = 5'b00010;
        repeat (6) @(negedge clk);
        game_tick = 1'b1;
        @(negedge clk);
        game_tick = 1'b0;
        checks++; if (dir !== 2'd0) begin errors++; $display("FAIL simul_dir got %0d exp 0", dir); end
        checks++; if (q_count !== 4'd1) begin errors++; $display("FAIL simul_q got %0d exp 1", q_count); end
        checks++; if (dir_changed !== 1'b0) begin errors++; $display("FAIL simul_chg got %0b exp 0", dir_changed); end
        btn = 5'b0;
        repeat (8) @(negedge clk);
        tick();
        checks++; if (dir !== 2'd3) begin errors++; $display("FAIL simul_next_dir got %0d exp 3", dir); end
    endtask

    task automatic test_restart_override();
        int d0, r0, c0;
        press(5'b00100);
        tick();
        checks++; if (dir !== 2'd2) begin errors++; $display("FAIL rstov_setup_dir got %0d exp 2", dir); end
        press(5'b00010);
        press(5'b00100);
        press(5'b10000);
        checks++; if (q_count !== 4'd3) begin errors++; $display("FAIL rstov_setup_q got %0d exp 3", q_count); end
        d0 = n_drop; r0 = n_rst; c0 = n_chg;
        press(5'b10001);
        checks++; if (n_rst - r0 !== 1) begin errors++; $display("FAIL rstov_pulse got %0d exp 1", n_rst - r0); end
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL rstov_q got %0d exp 0", q_count); end
        checks++; if (dir !== 2'd0) begin errors++; $display("FAIL rstov_dir got %0d exp 0", dir); end
        checks++; if (n_drop - d0 !== 0) begin errors++; $display("FAIL rstov_drop got %0d exp 0", n_drop - d0); end
        checks++; if (n_chg - c0 !== 0) begin errors++; $display("FAIL rstov_chg got %0d exp 0", n_chg - c0); end
    endtask

    task automatic test_reset_held();
        press(5'b00010);
        checks++; if (q_count !== 4'd1) begin errors++; $display("FAIL rsthold_setup_q got %0d exp 1", q_count); end
        rst = 1'b1;
        btn = 5'b00010;
        repeat (4) @(negedge clk);
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL rsthold_q got %0d exp 0", q_count); end
        checks++; if (dir !== 2'd0) begin errors++; $display("FAIL rsthold_dir got %0d exp 0", dir); end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (q_count !== 4'd0) begin errors++; $display("FAIL rsthold_early got %0d exp 0", q_count); end
        @(negedge clk);
        checks++; if (q_count !== 4'd1) begin errors++; $display("FAIL rsthold_enq got %0d exp 1", q_count); end
        btn = 5'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; btn = 5'b0; game_tick = 1'b0;
        @(negedge clk);
        test_reset();
        test_bounce();
        test_restart_empty();
        test_filter();
        test_overflow();
        test_priority();
        test_back_to_back();
        test_restart_override();
        test_reset_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
